// File: rtl/mealy_bit_conditioner.sv
// mealy_bit_conditioner
//   Input-conditioning stage in front of the Mealy sequence-detector core.
//   It synchronises a raw serial data pin and a bouncy strobe button, and
//   debounces the strobe with a four-state FSM. Each debounced press emits
//   exactly one single-cycle bit_valid pulse, with the synchronised data bit
//   captured into bit_out. A wrapping 8-bit counter of accepted bits is kept
//   for debug display.
//
// Ports
//   clk            : system clock
//   rst_n          : asynchronous active-low reset
//   ena_i          : harness enable; when low, the FSM/counters/bit hold and
//                    bit_valid is forced low (synchronisers keep running)
//   raw_data_i     : asynchronous serial data pin
//   raw_strobe_i   : asynchronous bouncy strobe pin, active high
//   bit_out_o      : data bit captured at the last accepted strobe
//   bit_valid_o    : one-cycle pulse, bit_out_o is new this cycle
//   strobe_level_o : debounced strobe level
//   bit_count_o    : accepted-bit counter, wraps 255 -> 0
module mealy_bit_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic       raw_data_i,
    input  logic       raw_strobe_i,
    output logic       bit_out_o,
    output logic       bit_valid_o,
    output logic       strobe_level_o,
    output logic [7:0] bit_count_o
);

    typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Two-flop synchronisers; only the *_s_q outputs are used downstream.
    logic data_m_q, data_s_q;
    logic strb_m_q, strb_s_q;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             bit_q;
    logic             valid_q;
    logic [7:0]       count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_m_q <= 1'b0;
            data_s_q <= 1'b0;
            strb_m_q <= 1'b0;
            strb_s_q <= 1'b0;
        end else begin
            data_m_q <= raw_data_i;
            data_s_q <= data_m_q;
            strb_m_q <= raw_strobe_i;
            strb_s_q <= strb_m_q;
        end
    end

    // Debounce FSM: a new level must persist for DEBOUNCE_CYCLES synchronised
    // cycles. Any glitch back to the old level restarts from the stable state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            S_LOW: begin
                if (strb_s_q) begin
                    state_d = S_RISE;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_RISE: begin
                if (!strb_s_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    accept  = 1'b1;   // the only edge that produces a bit
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!strb_s_q) begin
                    state_d = S_FALL;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_FALL: begin
                if (strb_s_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            valid_q <= ena_i & accept;
            if (ena_i) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (accept) begin
                    bit_q   <= data_s_q;
                    count_q <= count_q + 8'd1;
                end
            end
        end
    end

    assign bit_out_o      = bit_q;
    // Gate with ena so a pulse registered just before ena drops is suppressed.
    assign bit_valid_o    = valid_q & ena_i;
    // RISE is still debounced-low and FALL still debounced-high.
    assign strobe_level_o = (state_q == S_HIGH) || (state_q == S_FALL);
    assign bit_count_o    = count_q;

endmodule

// File: tb/tb_mealy_bit_conditioner.sv
module tb_mealy_bit_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       raw_data = 1'b0;
    logic       raw_strobe = 1'b0;
    logic       bit_out, bit_valid, strobe_level;
    logic [7:0] bit_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int np = 0;
    int last_at = -1;
    logic last_bo = 1'b0;
    logic last_lvl = 1'b0;

    mealy_bit_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena_i(ena),
        .raw_data_i(raw_data), .raw_strobe_i(raw_strobe),
        .bit_out_o(bit_out), .bit_valid_o(bit_valid),
        .strobe_level_o(strobe_level), .bit_count_o(bit_count)
    );

    always #5 clk = ~clk;

    // Advance n clock edges, sampling 1 time unit after each edge and
    // recording every bit_valid pulse seen.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bit_valid === 1'b1) begin
                np++;
                last_at  = cyc;
                last_bo  = bit_out;
                last_lvl = strobe_level;
            end
        end
    endtask

    task automatic press(input logic d, input int hi, input int lo);
        raw_data   = d;
        raw_strobe = 1'b1;
        watch(hi);
        raw_strobe = 1'b0;
        watch(lo);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        raw_strobe = 1'b0;
        raw_data = 1'b0;
        ena = 1'b1;
        watch(3);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        watch(5);
        checks++;
        if ({bit_out, bit_valid, strobe_level, bit_count} !== 11'b0) begin
            errors++;
            $display("FAIL reset_hold got %b exp 0", {bit_out, bit_valid, strobe_level, bit_count});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            watch(1);
            checks++;
            if ({bit_out, bit_valid, strobe_level, bit_count} !== 11'b0) begin
                errors++;
                $display("FAIL idle_cycle%0d got %b exp 0", i, {bit_out, bit_valid, strobe_level, bit_count});
            end
        end
    endtask

    task automatic test_clean_press();
        int t0, np0;
        t0 = cyc; np0 = np;
        press(1'b1, 12, 12);
        checks++;
        if (np - np0 !== 1) begin errors++; $display("FAIL clean_pulses got %0d exp 1", np - np0); end
        checks++;
        if (last_at - t0 !== D + 2) begin errors++; $display("FAIL clean_latency got %0d exp %0d", last_at - t0, D + 2); end
        checks++;
        if (last_bo !== 1'b1) begin errors++; $display("FAIL clean_bit got %b exp 1", last_bo); end
        checks++;
        if (last_lvl !== 1'b1) begin errors++; $display("FAIL clean_level_at_pulse got %b exp 1", last_lvl); end
        checks++;
        if (bit_count !== 8'd1) begin errors++; $display("FAIL clean_count got %0d exp 1", bit_count); end
        checks++;
        if (strobe_level !== 1'b0) begin errors++; $display("FAIL clean_level_released got %b exp 0", strobe_level); end
    endtask

    task automatic test_bounce();
        int np0, t_rise;
        np0 = np;
        raw_data = 1'b0;
        raw_strobe = 1'b1; watch(3);
        raw_strobe = 1'b0; watch(3);
        raw_strobe = 1'b1; watch(3);
        raw_strobe = 1'b0; watch(3);
        t_rise = cyc;
        raw_strobe = 1'b1; watch(10);
        raw_strobe = 1'b0; watch(10);
        checks++;
        if (np - np0 !== 1) begin errors++; $display("FAIL bounce_pulses got %0d exp 1", np - np0); end
        checks++;
        if (last_at - t_rise !== D + 2) begin errors++; $display("FAIL bounce_latency got %0d exp %0d", last_at - t_rise, D + 2); end
        checks++;
        if (bit_count !== 8'd2) begin errors++; $display("FAIL bounce_count got %0d exp 2", bit_count); end
        checks++;
        if (bit_out !== 1'b0) begin errors++; $display("FAIL bounce_bit got %b exp 0", bit_out); end
    endtask

    task automatic test_sequence();
        logic [3:0] seq;
        int np0;
        seq = 4'b1101;  // fed MSB first: 1,0,1,1
        do_reset();
        for (int k = 3; k >= 0; k--) begin
            np0 = np;
            press(seq[k], 10, 10);
            checks++;
            if (np - np0 !== 1 || last_bo !== seq[k]) begin
                errors++;
                $display("FAIL seq_bit%0d got pulses=%0d bit=%b exp pulses=1 bit=%b", 3 - k, np - np0, last_bo, seq[k]);
            end
        end
        checks++;
        if (bit_count !== 8'd4) begin errors++; $display("FAIL seq_count got %0d exp 4", bit_count); end
        // Data wiggling with no strobe must not disturb anything.
        np0 = np;
        for (int i = 0; i < 10; i++) begin
            raw_data = ~raw_data;
            watch(1);
        end
        checks++;
        if (np !== np0 || bit_out !== 1'b1 || bit_count !== 8'd4) begin
            errors++;
            $display("FAIL data_ignore got pulses=%0d bit=%b cnt=%0d exp 0,1,4", np - np0, bit_out, bit_count);
        end
    endtask

    task automatic test_ena_gating();
        int np0, t_ena;
        np0 = np;
        raw_data = 1'b0;
        raw_strobe = 1'b1;
        watch(4);           // FSM now in RISE with two stable cycles counted
        ena = 1'b0;
        watch(10);
        checks++;
        if (np !== np0 || strobe_level !== 1'b0 || bit_count !== 8'd4) begin
            errors++;
            $display("FAIL ena_hold got pulses=%0d lvl=%b cnt=%0d exp 0,0,4", np - np0, strobe_level, bit_count);
        end
        ena = 1'b1;
        t_ena = cyc;
        watch(4);
        checks++;
        if (np - np0 !== 1 || last_at - t_ena !== 2) begin
            errors++;
            $display("FAIL ena_resume got pulses=%0d delay=%0d exp 1,2", np - np0, last_at - t_ena);
        end
        checks++;
        if (bit_count !== 8'd5 || bit_out !== 1'b0) begin
            errors++;
            $display("FAIL ena_result got cnt=%0d bit=%b exp 5,0", bit_count, bit_out);
        end
        raw_strobe = 1'b0;
        watch(10);
    endtask

    task automatic test_wrap_and_reset();
        int np0, t_rel;
        do_reset();
        np0 = np;
        for (int i = 0; i < 255; i++) press(i[0], 8, 8);
        checks++;
        if (bit_count !== 8'd255) begin errors++; $display("FAIL count_255 got %0d exp 255", bit_count); end
        press(1'b1, 8, 8);
        checks++;
        if (bit_count !== 8'd0 || np - np0 !== 256) begin
            errors++;
            $display("FAIL count_wrap got cnt=%0d pulses=%0d exp 0,256", bit_count, np - np0);
        end
        press(1'b1, 8, 8);
        raw_strobe = 1'b1;
        watch(8);           // held press: count=2, bit=1, level=1
        checks++;
        if (bit_count !== 8'd2 || bit_out !== 1'b1 || strobe_level !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d bit=%b lvl=%b exp 2,1,1", bit_count, bit_out, strobe_level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bit_out, bit_valid, strobe_level, bit_count} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", {bit_out, bit_valid, strobe_level, bit_count});
        end
        watch(3);
        rst_n = 1'b1;
        t_rel = cyc;
        np0 = np;
        watch(10);          // strobe still held: a fresh full debounce
        checks++;
        if (np - np0 !== 1 || last_at - t_rel !== D + 2 || bit_count !== 8'd1) begin
            errors++;
            $display("FAIL held_after_reset got pulses=%0d delay=%0d cnt=%0d exp 1,%0d,1",
                     np - np0, last_at - t_rel, bit_count, D + 2);
        end
        raw_strobe = 1'b0;
        watch(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_ena_gating();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_bit_conditioner.md
Name: mealy_bit_conditioner

Overview:
- Input-conditioning stage placed directly upstream of the Mealy sequence-detector core inside the same TinyTapeout top.
- Takes a raw serial data pin and a raw, bouncy "bit strobe" button pin.
- Synchronises and debounces the strobe, then emits exactly one clean one-cycle bit_valid pulse per debounced press, with the sampled data bit attached.
- Also keeps a wrapping count of accepted bits for debug display on uo_out.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive synchronised cycles the strobe must hold a new level before that level is accepted. Legal range 2..255.
- CNT_W, 8: width of the debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- ena, input, 1: design enable from the TT harness.
- raw_data, input, 1: asynchronous serial data pin (ui_in[0]).
- raw_strobe, input, 1: asynchronous bouncy strobe pin (ui_in[1]); active high.
- bit_out, output, 1: data bit captured at the last accepted strobe.
- bit_valid, output, 1: one-cycle pulse; bit_out is new this cycle. Drives the Mealy core's input-valid.
- strobe_level, output, 1: debounced strobe level.
- bit_count, output, 8: accepted-bit counter; wraps 255 -> 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All sync flops, counter and outputs go to 0.
  - FSM goes to S_LOW.
  - Reset mid-press: on release of reset the FSM restarts in S_LOW. A strobe still held high is treated as a new press and must pass full debounce.
- Synchronisers: raw_data and raw_strobe each pass through 2 flops (d_s, s_s). No logic reads the raw pins directly.
- FSM states, evaluated on s_s:
  - S_LOW: strobe_level=0. If s_s=1, go to S_RISE with cnt=1.
  - S_RISE: if s_s=0, go to S_LOW with cnt=0 (bounce). Else if cnt==DEBOUNCE_CYCLES-1, go to S_HIGH. Else cnt++.
  - S_HIGH: strobe_level=1. If s_s=0, go to S_FALL with cnt=1.
  - S_FALL: if s_s=1, go to S_HIGH with cnt=0. Else if cnt==DEBOUNCE_CYCLES-1, go to S_LOW. Else cnt++.
- Transition S_RISE -> S_HIGH (same edge, all registered):
  - bit_valid=1 for exactly one cycle.
  - bit_out <= d_s.
  - bit_count++ (modulo 256).
- No other transition produces bit_valid. Falling edges never produce a pulse.
- Latency: a clean raw_strobe rise sampled at edge 0 gives bit_valid high after edge DEBOUNCE_CYCLES+2. Default: 18 cycles.
- bit_out holds its value between pulses. Data changes without a strobe are ignored.
- ena=0:
  - FSM, cnt, bit_out and bit_count hold their values.
  - bit_valid forced 0.
  - Synchronisers keep running.
  - On ena returning to 1 the FSM resumes from its held state.
- Simultaneous data change and strobe acceptance: bit_out takes d_s as registered on the accepting edge. The data pin's own 2-cycle sync delay applies.
- Minimum spacing between bit_valid pulses: 2*DEBOUNCE_CYCLES cycles.
- bit_valid is never high on two consecutive cycles.

Test Plan (DEBOUNCE_CYCLES=4 override for speed):
- Reset then idle:
  - Hold rst_n=0 for 5 cycles, release, raw pins 0 for 20 cycles.
  - Required: bit_out=0, bit_valid=0, strobe_level=0, bit_count=0 throughout.
- Clean press:
  - raw_data=1, raw_strobe 0->1 at edge 10, held.
  - Required: single bit_valid pulse in the cycle after edge 16, bit_out=1, bit_count=1, strobe_level=1.
- Bounce rejection:
  - raw_strobe toggles 1,0,1,0 for 3 cycles each, then stays high.
  - Required: exactly one bit_valid, 6 cycles after the final rise; bit_count increments by 1.
- Sequence 1,0,1,1 fed as four clean presses, each held 10 cycles with 10 low cycles between.
  - Required: four pulses with bit_out 1,0,1,1 respectively; bit_count=4.
- ena gating:
  - Drop ena during the S_RISE count (after 2 stable cycles), keep strobe high for 10 cycles, then restore ena.
  - Required: no pulse while ena=0; pulse 2 cycles after ena returns.
- Wrap and async reset:
  - Apply 256 presses: bit_count reads 0.
  - Assert rst_n mid-press: outputs 0 immediately, without waiting for a clock edge.
